// File: rtl/rv_split_join_ctrl_if.sv
// Request/response channel between the warp-control stage and the split/join sequencer,
// plus the per-warp stack status flags.
interface rv_split_join_ctrl_if #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 32
);
  localparam int WID_W = $clog2(NUM_WARPS);

  // Both channels transfer on a clock edge where valid && ready; the sender holds valid and every
  // payload field stable until that edge, and valid never depends combinationally on ready.
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_is_split;
  logic [WID_W-1:0]       req_wid;
  logic [NUM_THREADS-1:0] req_tmask;
  logic [NUM_THREADS-1:0] req_then_mask;
  logic [NUM_THREADS-1:0] req_else_mask;
  logic [PC_W-1:0]        req_else_pc;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WID_W-1:0]       rsp_wid;
  logic [NUM_THREADS-1:0] rsp_tmask;
  logic [PC_W-1:0]        rsp_pc;
  logic                   rsp_pc_valid;
  logic                   rsp_error;

  logic [NUM_WARPS-1:0]   stack_empty;
  logic [NUM_WARPS-1:0]   stack_full;

  modport master (
    output req_valid, req_is_split, req_wid, req_tmask, req_then_mask, req_else_mask, req_else_pc,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_wid, rsp_tmask, rsp_pc, rsp_pc_valid, rsp_error,
    input  stack_empty, stack_full
  );

  modport slave (
    input  req_valid, req_is_split, req_wid, req_tmask, req_then_mask, req_else_mask, req_else_pc,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_wid, rsp_tmask, rsp_pc, rsp_pc_valid, rsp_error,
    output stack_empty, stack_full
  );
endinterface

// File: rtl/rv_split_join_ctrl.sv
// Per-warp IPDOM reconvergence stacks and the FSM that turns SPLIT/JOIN requests into
// push/pop operations on the addressed warp's stack.
module RV_ipdom_stack #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             pair,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] d,
  output logic             index,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    top;
  logic [DEPTH-1:0] part_q;
  logic [WIDTH-1:0] q1_mem [DEPTH];
  logic [WIDTH-1:0] q2_mem [DEPTH];

  assign top   = cnt_q - AW'(1);
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == AW'(DEPTH - 1));
  // One slot per split; a paired slot yields q2 first, then q1 on the second pop.
  assign index = part_q[top];
  assign d     = part_q[top] ? q1_mem[top] : q2_mem[top];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      part_q <= '0;
    end else if (push) begin
      cnt_q         <= cnt_q + AW'(1);
      part_q[cnt_q] <= ~pair;
    end else if (pop) begin
      if (part_q[top]) cnt_q <= cnt_q - AW'(1);
      else             part_q[top] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q1_mem[cnt_q] <= q1;
      q2_mem[cnt_q] <= q2;
    end
  end
endmodule

module rv_split_join_ctrl #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int STACK_DEPTH = 4,
  parameter int PC_W        = 32
) (
  input  logic                clk,
  input  logic                reset,
  rv_split_join_ctrl_if.slave bus,
  output logic [2:0]          dbg_state_o
);
  localparam int WID_W = $clog2(NUM_WARPS);
  localparam int EW    = NUM_THREADS + PC_W;

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_READ, S_POP, S_RESP} state_e;

  state_e                 state_q;
  logic [WID_W-1:0]       wid_q;
  logic [NUM_THREADS-1:0] tmask_q, then_q, else_q;
  logic [PC_W-1:0]        else_pc_q;

  logic                   rsp_valid_q, rsp_error_q, rsp_pc_valid_q;
  logic [WID_W-1:0]       rsp_wid_q;
  logic [NUM_THREADS-1:0] rsp_tmask_q;
  logic [PC_W-1:0]        rsp_pc_q;

  logic [NUM_WARPS-1:0]   empty_w, full_w, index_w;
  logic [EW-1:0]          d_w [NUM_WARPS];
  logic [EW-1:0]          sel_d;
  logic                   div, push, pop;

  assign div   = (|then_q) && (|else_q);
  assign sel_d = d_w[wid_q];
  // Strobes are masked by reset so an in-flight operation never touches a stack.
  assign push  = (state_q == S_PUSH) && !full_w[wid_q] && !reset;
  assign pop   = (state_q == S_POP) && !reset;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_stack
    RV_ipdom_stack #(.WIDTH(EW), .DEPTH(STACK_DEPTH)) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push && (wid_q == WID_W'(w))),
      .pop   (pop && (wid_q == WID_W'(w))),
      .pair  (div),
      .q1    ({tmask_q, {PC_W{1'b0}}}),
      .q2    ({else_q, else_pc_q}),
      .d     (d_w[w]),
      .index (index_w[w]),
      .empty (empty_w[w]),
      .full  (full_w[w])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wid_q          <= '0;
      tmask_q        <= '0;
      then_q         <= '0;
      else_q         <= '0;
      else_pc_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_error_q    <= 1'b0;
      rsp_pc_valid_q <= 1'b0;
      rsp_wid_q      <= '0;
      rsp_tmask_q    <= '0;
      rsp_pc_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          wid_q     <= bus.req_wid;
          tmask_q   <= bus.req_tmask;
          then_q    <= bus.req_then_mask;
          else_q    <= bus.req_else_mask;
          else_pc_q <= bus.req_else_pc;
          state_q   <= bus.req_is_split ? S_PUSH : S_READ;
        end
        S_PUSH: begin
          rsp_valid_q    <= 1'b1;
          rsp_wid_q      <= wid_q;
          rsp_pc_valid_q <= 1'b0;
          rsp_pc_q       <= '0;
          rsp_error_q    <= full_w[wid_q];
          rsp_tmask_q    <= (!full_w[wid_q] && div) ? then_q : tmask_q;
          state_q        <= S_RESP;
        end
        S_READ: begin
          if (empty_w[wid_q]) begin
            rsp_valid_q    <= 1'b1;
            rsp_wid_q      <= wid_q;
            rsp_error_q    <= 1'b1;
            rsp_tmask_q    <= '0;
            rsp_pc_q       <= '0;
            rsp_pc_valid_q <= 1'b0;
            state_q        <= S_RESP;
          end else begin
            state_q <= S_POP;
          end
        end
        S_POP: begin
          rsp_valid_q    <= 1'b1;
          rsp_wid_q      <= wid_q;
          rsp_error_q    <= 1'b0;
          rsp_tmask_q    <= sel_d[EW-1 -: NUM_THREADS];
          rsp_pc_q       <= sel_d[PC_W-1:0];
          rsp_pc_valid_q <= ~index_w[wid_q];
          state_q        <= S_RESP;
        end
        S_RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_wid      = rsp_wid_q;
  assign bus.rsp_tmask    = rsp_tmask_q;
  assign bus.rsp_pc       = rsp_pc_q;
  assign bus.rsp_pc_valid = rsp_pc_valid_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.stack_empty  = empty_w;
  assign bus.stack_full   = full_w;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_rv_split_join_ctrl.sv
// Bench for rv_split_join_ctrl: directed scenarios plus random SPLIT/JOIN traffic checked
// against a list-based reconvergence model through an expected-response queue.
module tb_rv_split_join_ctrl;
  localparam int NW = 4, NT = 4, SD = 4, PW = 32;
  localparam int WW = $clog2(NW);
  localparam int EW = WW + 2 + NT + PW + 2 * NW;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  rv_split_join_ctrl_if #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_W(PW)) bus ();

  rv_split_join_ctrl #(.NUM_WARPS(NW), .NUM_THREADS(NT), .STACK_DEPTH(SD), .PC_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rsp_mode = 2;  // 0 random ready, 1 ready held low, 2 ready held high
  int pops_in_reset = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Each warp keeps the list of answers future JOINs will return (last = reconvergence entry
  // that closes one split level) and the number of open split levels.
  typedef struct packed {
    logic [NT-1:0] m;
    logic [PW-1:0] pc;
    logic          pcv;
    logic          last;
  } item_t;
  item_t mdl_q[NW][$];
  int    nsplit[NW];

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      mdl_q[w].delete();
      nsplit[w] = 0;
    end
  endtask

  task automatic model_step(input logic split, input logic [WW-1:0] wid, input logic [NT-1:0] tm,
                            input logic [NT-1:0] th, input logic [NT-1:0] el, input logic [PW-1:0] pc,
                            output logic [EW-1:0] e, output int lat);
    logic          err, pcv;
    logic [NT-1:0] m;
    logic [PW-1:0] p;
    logic [NW-1:0] ev, fv;
    item_t         it;
    err = 1'b0; pcv = 1'b0; m = '0; p = '0;
    if (split) begin
      lat = 2;
      if (nsplit[wid] == SD - 1) begin
        err = 1'b1;
        m   = tm;
      end else begin
        nsplit[wid]++;
        mdl_q[wid].push_back('{m: tm, pc: '0, pcv: 1'b0, last: 1'b1});
        if (th != 0 && el != 0) begin
          mdl_q[wid].push_back('{m: el, pc: pc, pcv: 1'b1, last: 1'b0});
          m = th;
        end else begin
          m = tm;
        end
      end
    end else if (mdl_q[wid].size() == 0) begin
      lat = 2;
      err = 1'b1;
    end else begin
      lat = 3;
      it  = mdl_q[wid].pop_back();
      m   = it.m;
      pcv = it.pcv;
      p   = it.pcv ? it.pc : '0;
      if (it.last) nsplit[wid]--;
    end
    for (int w = 0; w < NW; w++) begin
      ev[w] = (mdl_q[w].size() == 0);
      fv[w] = (nsplit[w] == SD - 1);
    end
    e = {wid, err, pcv, m, p, ev, fv};
  endtask

  // ---------------- response ready generator ----------------
  always @(posedge clk) begin
    #2;
    case (rsp_mode)
      0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
      1:       bus.rsp_ready = 1'b0;
      default: bus.rsp_ready = 1'b1;
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e, a;
    if (reset) begin
      if (dut.pop) pops_in_reset++;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp wid=%0d tmask=%b err=%b", bus.rsp_wid, bus.rsp_tmask, bus.rsp_error);
      end else begin
        e = exp_q.pop_front();
        a = {bus.rsp_wid, bus.rsp_error, bus.rsp_pc_valid, bus.rsp_tmask,
             (e[EW-WW-2] ? bus.rsp_pc : {PW{1'b0}}), bus.stack_empty, bus.stack_full};
        if (a !== e) begin
          failures++;
          $display("FAIL rsp got={wid,err,pcv,tmask,pc,empty,full}=%h expected=%h", a, e);
        end
      end
    end
  end

  // ---------------- driver tasks (entered at posedge+2) ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  task automatic issue(input logic split, input logic [WW-1:0] wid, input logic [NT-1:0] tm,
                       input logic [NT-1:0] th, input logic [NT-1:0] el, input logic [PW-1:0] pc);
    logic [EW-1:0] e;
    int exp_lat, lat, n;
    model_step(split, wid, tm, th, el, pc, e, exp_lat);
    exp_q.push_back(e);
    bus.req_valid     = 1'b1;
    bus.req_is_split  = split;
    bus.req_wid       = wid;
    bus.req_tmask     = tm;
    bus.req_then_mask = th;
    bus.req_else_mask = el;
    bus.req_else_pc   = pc;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout got=0 expected=1");
    end
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk); #2; lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL rsp_timeout got=pending expected=none");
      exp_q.delete();
    end
  endtask

  task automatic send(input logic split, input logic [WW-1:0] wid, input logic [NT-1:0] tm,
                      input logic [NT-1:0] th, input logic [NT-1:0] el, input logic [PW-1:0] pc);
    issue(split, wid, tm, th, el, pc);
    wait_done();
  endtask

  task automatic check_reset_vals(input string name);
    check(name, 64'({bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.rsp_pc_valid, bus.rsp_tmask,
                     bus.rsp_pc, bus.rsp_wid, bus.stack_empty, bus.stack_full}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, {NT{1'b0}}, {PW{1'b0}}, {WW{1'b0}}, {NW{1'b1}}, {NW{1'b0}}}));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WW+2+NT+PW-1:0] cap;
    logic [NT-1:0] tm, r;
    bus.req_valid = 1'b0; bus.req_is_split = 1'b0; bus.req_wid = '0; bus.req_tmask = '0;
    bus.req_then_mask = '0; bus.req_else_mask = '0; bus.req_else_pc = '0; bus.rsp_ready = 1'b1;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset_values");
    reset = 1'b0;
    @(posedge clk); #2;

    // divergent split, then two joins on warp 1
    send(1'b1, 2'd1, 4'b1111, 4'b0011, 4'b1100, 32'h100);
    send(1'b0, 2'd1, '0, '0, '0, '0);
    send(1'b0, 2'd1, '0, '0, '0, '0);
    // uniform split and join on warp 0
    send(1'b1, 2'd0, 4'b1111, 4'b1111, 4'b0000, 32'h200);
    send(1'b0, 2'd0, '0, '0, '0, '0);
    // fill warp 2, then overflow; underflow on warp 3
    send(1'b1, 2'd2, 4'b1111, 4'b0011, 4'b1100, 32'h300);
    send(1'b1, 2'd2, 4'b0011, 4'b0001, 4'b0010, 32'h304);
    send(1'b1, 2'd2, 4'b0001, 4'b0001, 4'b0000, 32'h308);
    send(1'b1, 2'd2, 4'b0101, 4'b0100, 4'b0001, 32'h30c);
    send(1'b0, 2'd3, '0, '0, '0, '0);

    // backpressure: response must hold for 5 cycles with ready low
    rsp_mode = 1;
    @(posedge clk); #2;
    issue(1'b1, 2'd0, 4'b1010, 4'b1000, 4'b0010, 32'h400);
    cap = {bus.rsp_wid, bus.rsp_error, bus.rsp_pc_valid, bus.rsp_tmask, bus.rsp_pc};
    repeat (5) begin
      @(negedge clk);
      check("hold_fields", 64'({bus.rsp_wid, bus.rsp_error, bus.rsp_pc_valid, bus.rsp_tmask, bus.rsp_pc}),
            64'(cap));
      check("hold_ctrl", 64'({bus.rsp_valid, bus.req_ready}), 64'(2'b10));
    end
    @(posedge clk); #2;
    rsp_mode = 2;
    wait_done();

    // interleave warps 0 and 3
    send(1'b1, 2'd3, 4'b1111, 4'b0110, 4'b1001, 32'h500);
    send(1'b0, 2'd0, '0, '0, '0, '0);
    send(1'b1, 2'd0, 4'b1000, 4'b1000, 4'b0000, 32'h600);
    send(1'b0, 2'd3, '0, '0, '0, '0);
    send(1'b0, 2'd0, '0, '0, '0, '0);
    send(1'b0, 2'd3, '0, '0, '0, '0);
    send(1'b0, 2'd0, '0, '0, '0, '0);

    // random traffic with random response backpressure
    rsp_mode = 0;
    for (int i = 0; i < 300; i++) begin
      tm = NT'($urandom_range(1, (1 << NT) - 1));
      r  = ($urandom_range(0, 3) == 0) ? tm : NT'($urandom);
      send(1'($urandom_range(0, 1)), WW'($urandom_range(0, NW - 1)), tm, tm & r, tm & ~r, $urandom);
    end

    // reset while the controller sits in POP
    rsp_mode = 2;
    @(posedge clk); #2;
    send(1'b1, 2'd1, 4'b1111, 4'b0011, 4'b1100, 32'h700);
    bus.req_valid = 1'b1; bus.req_is_split = 1'b0; bus.req_wid = 2'd1;
    @(posedge clk); #2;          // accepted: READ
    bus.req_valid = 1'b0;
    @(posedge clk); #2;          // POP
    reset = 1'b1;
    @(posedge clk); #2;
    check_reset_vals("reset_in_pop");
    check("pops_in_reset", 64'(pops_in_reset), 64'd0);
    reset = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      check("dropped_rsp", 64'({bus.rsp_valid, bus.stack_empty}), 64'({1'b0, {NW{1'b1}}}));
    end
    @(posedge clk); #2;
    send(1'b0, 2'd1, '0, '0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
